note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a stored song by walking a synchronous song ROM one note word at a time. For each note it looks up the note duration through the note length table, times the note in clock cycles and drives the tone generator's pitch and enable. It sits between the song ROM / note length table and the PWM tone generator, and is started and stopped from button logic.

## Interface
Parameters:
- `ADDR_W`, 6: song ROM address width; the song holds at most 2^ADDR_W words.
- `GAP_CYCLES`, 250000: silent articulation gap at the end of every note, in cycles (10 ms at 25 MHz).

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_start`  in  1  level, sampled; begins playback from address 0 when idle.
- `i_stop`  in  1  level, sampled; aborts playback from any state.
- `i_loop`  in  1  sampled at end of song; restart at address 0 when high.
- `o_rom_addr`  out  ADDR_W  song ROM address; ROM data is valid one cycle after the address.
- `i_rom_data`  in  16  song word: [15] last, [14] rest, [12:8] note_len, [7:0] pitch; [13] ignored.
- `o_note_len`  out  5  index to the note length table.
- `i_duration`  in  32  combinational table result for `o_note_len`, in cycles.
- `o_pitch`  out  8  pitch code to the tone generator; held for the whole note.
- `o_tone_en`  out  1  tone generator enable.
- `o_note_strobe`  out  1  one-cycle pulse at the start of each note.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, LATCH, ARM, PLAY.
- IDLE:
  - If `i_start` is high and `i_stop` is low, clear the address to 0 and go to FETCH.
- FETCH:
  - `o_rom_addr` is stable and the ROM registers it. Go to LATCH.
- LATCH:
  - Capture `i_rom_data` into the last, rest, `o_note_len` and `o_pitch` registers. Go to ARM.
- ARM:
  - Load the 32-bit counter with max(`i_duration`, 1) − 1.
  - Pulse `o_note_strobe`. Go to PLAY.
- PLAY:
  - `o_tone_en` = !rest && (counter ≥ GAP_CYCLES).
  - While the counter is nonzero, decrement it by 1.
  - When the counter reaches 0, end the note:
    - Not last and address < 2^ADDR_W−1: address +1, go to FETCH.
    - Last, or address = 2^ADDR_W−1 (treated as last; the address never wraps mid-song): if `i_loop` is high, address := 0 and go to FETCH; otherwise go to IDLE.
- `i_stop` high in any non-IDLE state:
  - Go to IDLE on the next edge.
  - `o_tone_en` and `o_note_strobe` are 0 from that edge on.
- `i_start` and `i_stop` high together: stop wins. `i_start` is ignored while busy.
- When the duration is ≤ GAP_CYCLES, the note is entirely silent. This is legal and not an error.

## Timing
- Reset values: state IDLE; `o_rom_addr` 0; `o_note_len` 0; `o_pitch` 0; `o_tone_en`, `o_note_strobe`, `o_busy` 0; counter 0.
- All outputs are registered except `o_busy` and `o_tone_en`, which decode from state and counter.
- Start latency: `i_start` sampled high at edge t gives FETCH at t+1, LATCH at t+2, ARM at t+3 (strobe), and first PLAY cycle at t+4.
- PLAY lasts exactly max(`i_duration`, 1) cycles.
- Note period = duration + 3 cycles (FETCH, LATCH and ARM overhead). Tone is off during the overhead.
- `o_tone_en` is high for exactly max(0, D − GAP_CYCLES) cycles per non-rest note, where D = max(`i_duration`, 1).
- `o_pitch` and `o_note_len` change only in LATCH.
- `i_duration` is sampled only in ARM; the table must settle within one cycle of `o_note_len`.
- Reset asserted mid-note: all outputs go to their reset values immediately (asynchronous).

## Structure
- Shared package `note_seq_pkg` holds:
  - the state enum;
  - the song-word field positions (LAST_BIT = 15, REST_BIT = 14, LEN_MSB/LSB = 12/8, PITCH_MSB/LSB = 7/0).
- One natural sub-module, `note_timer`:
  - a loadable 32-bit down-counter with a zero flag and a `≥ GAP_CYCLES` compare;
  - parameter GAP_CYCLES.
- The note length table itself is instantiated by the parent, not inside this block.

## Test plan
Bench settings: GAP_CYCLES = 4; the table is modelled as duration = 10·(len+1).

- Song {len 0, pitch 0x21} (last): start → strobe at t+3. PLAY runs 10 cycles with tone_en high for the first 6. Then IDLE; busy drops on the 11th cycle after ARM.
- Three-note song {len 1 pitch 5; rest len 0; len 2 pitch 9 last}: addresses 0, 1, 2 are fetched and pitch sequences 5, x, 9. The note periods are 23, 13 and 33 cycles. tone_en stays low for the whole rest note.
- Loop=1 on a two-note song: after the last note the address returns to 0 and FETCH follows immediately, giving 3 full passes with no IDLE cycle. Dropping loop ends the song after the current pass.
- Stop asserted mid-PLAY of note 2: IDLE on the next edge, tone_en 0 and busy 0. A later start replays from address 0.
- Start and stop asserted together from IDLE: stays IDLE. Start re-asserted while busy: the timing of the current note is unchanged.
- Duration-guard cases:
  - Model override: duration = 0 → PLAY lasts 1 cycle and tone_en stays 0.
  - Full ROM with no last bit: playback stops after address 63 (ADDR_W = 6).

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types and song-word layout for the note sequencer.
package note_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ARM,
        S_PLAY
    } state_e;

    localparam int unsigned LAST_BIT  = 15;
    localparam int unsigned REST_BIT  = 14;
    localparam int unsigned LEN_MSB   = 12;
    localparam int unsigned LEN_LSB   = 8;
    localparam int unsigned PITCH_MSB = 7;
    localparam int unsigned PITCH_LSB = 0;

    // Counter preload so that PLAY lasts max(dur, 1) cycles.
    function automatic logic [31:0] arm_value(input logic [31:0] dur);
        return (dur == '0) ? '0 : dur - 32'd1;
    endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable 32-bit note down-counter with zero flag and articulation-gap compare.
module note_timer #(
    parameter int unsigned GAP_CYCLES = 250000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        dec_i,
    output logic        zero_o,
    output logic        ge_gap_o
);

    logic [31:0] count_q, count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o   = (count_q == '0);
    assign ge_gap_o = (count_q >= GAP_CYCLES);

endmodule

// File: rtl/note_sequencer.sv
// Song player: walks the song ROM, times each note and drives the tone generator.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned GAP_CYCLES = 250000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic [4:0]        o_note_len,
    input  logic [31:0]       i_duration,
    output logic [7:0]        o_pitch,
    output logic              o_tone_en,
    output logic              o_note_strobe,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              rest_q, rest_d;
    logic [4:0]        len_q, len_d;
    logic [7:0]        pitch_q, pitch_d;
    logic              strobe_q, strobe_d;
    logic              tmr_load, tmr_dec, tmr_zero, tmr_ge_gap;
    logic              rom_bit13_unused;

    assign rom_bit13_unused = i_rom_data[13];

    note_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_timer (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .load_i    (tmr_load),
        .load_val_i(arm_value(i_duration)),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero),
        .ge_gap_o  (tmr_ge_gap)
    );

    // Next-state, note capture and timer control; stop overrides everything.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        rest_d   = rest_q;
        len_d    = len_q;
        pitch_d  = pitch_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if ((state_q != S_IDLE) && i_stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    last_d  = i_rom_data[LAST_BIT];
                    rest_d  = i_rom_data[REST_BIT];
                    len_d   = i_rom_data[LEN_MSB:LEN_LSB];
                    pitch_d = i_rom_data[PITCH_MSB:PITCH_LSB];
                    state_d = S_ARM;
                end
                S_ARM: begin
                    tmr_load = 1'b1;
                    state_d  = S_PLAY;
                end
                S_PLAY: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (!last_q && (addr_q != ADDR_MAX)) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else if (i_loop) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        strobe_d = (state_d == S_ARM);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            last_q   <= 1'b0;
            rest_q   <= 1'b0;
            len_q    <= '0;
            pitch_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            rest_q   <= rest_d;
            len_q    <= len_d;
            pitch_q  <= pitch_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_rom_addr    = addr_q;
    assign o_note_len    = len_q;
    assign o_pitch       = pitch_q;
    assign o_note_strobe = strobe_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_tone_en     = (state_q == S_PLAY) && !rest_q && tmr_ge_gap;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer (GAP_CYCLES = 4, duration = 10*(len+1)).
module tb_note_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_loop = 1'b0;
    logic [5:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic [4:0]  o_note_len;
    logic [31:0] i_duration;
    logic [7:0]  o_pitch;
    logic        o_tone_en;
    logic        o_note_strobe;
    logic        o_busy;

    logic [15:0] rom [64];
    bit          dur_zero = 1'b0;

    int errs = 0;
    int checks = 0;

    note_sequencer #(
        .ADDR_W    (6),
        .GAP_CYCLES(4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_loop       (i_loop),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_note_len   (o_note_len),
        .i_duration   (i_duration),
        .o_pitch      (o_pitch),
        .o_tone_en    (o_tone_en),
        .o_note_strobe(o_note_strobe),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous song ROM and combinational length table models.
    always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];
    assign i_duration = dur_zero ? 32'd0 : 32'd10 * (32'(o_note_len) + 32'd1);

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    // Per-run observations.
    int          strobe_cyc[$];
    logic [5:0]  strobe_addr[$];
    logic [7:0]  strobe_pitch[$];
    logic [4:0]  strobe_len[$];
    int          tone_cnt[$];
    int          end_cyc;
    logic        end_tone;
    logic        tone_before_stop;

    // Start a song and observe until busy drops; optional stop, loop-drop and re-start injections.
    task automatic play_song(input int stop_at, input int loop_drop_at, input int start_again_at,
                             input int limit);
        int cyc;
        strobe_cyc.delete();
        strobe_addr.delete();
        strobe_pitch.delete();
        strobe_len.delete();
        tone_cnt.delete();
        end_cyc = -1;
        end_tone = 1'b0;
        tone_before_stop = 1'b0;
        i_start = 1'b1;
        tick();
        cyc = 1;
        i_start = 1'b0;
        while (cyc < limit) begin
            if (!o_busy) begin
                end_cyc = cyc;
                end_tone = o_tone_en;
                break;
            end
            if (o_note_strobe) begin
                strobe_cyc.push_back(cyc);
                strobe_addr.push_back(o_rom_addr);
                strobe_pitch.push_back(o_pitch);
                strobe_len.push_back(o_note_len);
                tone_cnt.push_back(0);
            end
            if (o_tone_en && (tone_cnt.size() > 0)) tone_cnt[tone_cnt.size()-1] += 1;
            if (cyc == stop_at) begin
                tone_before_stop = o_tone_en;
                i_stop = 1'b1;
            end
            if (cyc == loop_drop_at) i_loop = 1'b0;
            i_start = (cyc == start_again_at);
            tick();
            cyc++;
        end
        i_stop = 1'b0;
        i_start = 1'b0;
        if (end_cyc < 0) begin
            chk("song_timeout", 32'(limit), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        bit          dz;
        int          exp_play;
        int          exp_tone;
        int          exp_pitch;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'h8021, 1'b0, 10, 6, 8'h21, 0};
        vecs[1] = '{16'h8105, 1'b0, 20, 16, 8'h05, 1};
        vecs[2] = '{16'hC233, 1'b0, 30, 0, 8'h33, 2};
        vecs[3] = '{16'hBFFF, 1'b0, 320, 316, 8'hFF, 31};
        vecs[4] = '{16'h8021, 1'b1, 1, 0, 8'h21, 0};

        clear_rom();
        #12;
        chk("reset_busy", o_busy, 0);
        chk("reset_tone", o_tone_en, 0);
        chk("reset_strobe", o_note_strobe, 0);
        chk("reset_addr", o_rom_addr, 0);
        chk("reset_len", o_note_len, 0);
        chk("reset_pitch", o_pitch, 0);
        i_rst_n = 1'b1;
        tick();

        // Single-note songs from the vector table.
        for (int v = 0; v < 5; v++) begin
            clear_rom();
            rom[0] = vecs[v].word;
            dur_zero = vecs[v].dz;
            play_song(-1, -1, -1, 1000);
            chk($sformatf("v%0d_strobes", v), strobe_cyc.size(), 1);
            if (strobe_cyc.size() == 1) begin
                chk($sformatf("v%0d_strobe_cyc", v), strobe_cyc[0], 3);
                chk($sformatf("v%0d_addr", v), strobe_addr[0], 0);
                chk($sformatf("v%0d_pitch", v), strobe_pitch[0], vecs[v].exp_pitch);
                chk($sformatf("v%0d_len", v), strobe_len[0], vecs[v].exp_len);
                chk($sformatf("v%0d_play", v), end_cyc - strobe_cyc[0] - 1, vecs[v].exp_play);
                chk($sformatf("v%0d_tone", v), tone_cnt[0], vecs[v].exp_tone);
            end
            dur_zero = 1'b0;
            tick();
        end

        // Three-note song with a rest in the middle.
        clear_rom();
        rom[0] = 16'h0105;
        rom[1] = 16'h4077;
        rom[2] = 16'h8209;
        play_song(-1, -1, -1, 1000);
        chk("three_strobes", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            chk("three_period1", strobe_cyc[1] - strobe_cyc[0], 23);
            chk("three_period2", strobe_cyc[2] - strobe_cyc[1], 13);
            chk("three_last_play", end_cyc - strobe_cyc[2] - 1, 30);
            for (int k = 0; k < 3; k++) chk($sformatf("three_addr%0d", k), strobe_addr[k], k);
            chk("three_pitch0", strobe_pitch[0], 8'h05);
            chk("three_pitch2", strobe_pitch[2], 8'h09);
            chk("three_tone0", tone_cnt[0], 16);
            chk("three_tone_rest", tone_cnt[1], 0);
            chk("three_tone2", tone_cnt[2], 26);
        end
        tick();

        // Looping two-note song; loop dropped during the third pass.
        clear_rom();
        rom[0] = 16'h0001;
        rom[1] = 16'h8002;
        i_loop = 1'b1;
        play_song(-1, 60, -1, 1000);
        i_loop = 1'b0;
        chk("loop_strobes", strobe_cyc.size(), 6);
        chk("loop_end", end_cyc, 79);
        if (strobe_cyc.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("loop_cyc%0d", k), strobe_cyc[k], 3 + 13 * k);
                chk($sformatf("loop_addr%0d", k), strobe_addr[k], k % 2);
            end
        end
        tick();

        // Stop during the tone of note 2, then replay from address 0.
        clear_rom();
        rom[0] = 16'h0105;
        rom[1] = 16'h0106;
        rom[2] = 16'h8007;
        play_song(30, -1, -1, 1000);
        chk("stop_tone_before", tone_before_stop, 1);
        chk("stop_end", end_cyc, 31);
        chk("stop_tone_after", end_tone, 0);
        chk("stop_strobes", strobe_cyc.size(), 2);
        tick();
        chk("stop_strobe_idle", o_note_strobe, 0);
        play_song(-1, -1, -1, 1000);
        chk("replay_strobes", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            chk("replay_addr0", strobe_addr[0], 0);
            chk("replay_pitch2", strobe_pitch[2], 8'h07);
        end
        chk("replay_end", end_cyc, 60);
        tick();

        // Start and stop together from idle.
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        tick();
        chk("startstop_busy", o_busy, 0);
        i_start = 1'b0;
        i_stop = 1'b0;
        tick();

        // Start re-asserted while busy leaves note timing unchanged.
        clear_rom();
        rom[0] = 16'h8021;
        play_song(-1, -1, 6, 1000);
        chk("rearm_end", end_cyc, 14);
        chk("rearm_strobes", strobe_cyc.size(), 1);
        tick();
        chk("rearm_idle_after", o_busy, 0);

        // Full ROM with no last bit stops after address 63.
        for (int i = 0; i < 64; i++) rom[i] = {8'h00, 8'(i)};
        play_song(-1, -1, -1, 2000);
        chk("full_strobes", strobe_cyc.size(), 64);
        chk("full_end", end_cyc, 833);
        if (strobe_cyc.size() == 64) begin
            chk("full_last_addr", strobe_addr[63], 63);
            chk("full_last_pitch", strobe_pitch[63], 63);
        end
        tick();

        // Asynchronous reset mid-note.
        clear_rom();
        rom[0] = 16'h8021;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_tone_pre", o_tone_en, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_tone", o_tone_en, 0);
        chk("midrst_pitch", o_pitch, 0);
        chk("midrst_addr", o_rom_addr, 0);
        chk("midrst_len", o_note_len, 0);
        tick();
        i_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
